// File: rtl/traffic_conflict_monitor.sv
// Passive signal-head monitor: tracks the active phase from the four lamp lines
// and latches the first conflict/head/timing violation as a sticky fault code.
module traffic_conflict_monitor #(
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 64,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        NS_red,
  input  logic        NS_green,
  input  logic        EW_red,
  input  logic        EW_green,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  mon_state,
  output logic [15:0] phase_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NS     = 3'd1,
    S_EW     = 3'd2,
    S_ALLRED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(MAX_GREEN);

  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_CONFLICT = 3'd1;
  localparam logic [2:0] C_INVALID  = 3'd2;
  localparam logic [2:0] C_SHORT    = 3'd3;
  localparam logic [2:0] C_LONG     = 3'd4;
  localparam logic [2:0] C_STUCK    = 3'd5;

  state_t            r_state;
  logic [CNT_W-1:0]  r_dur;
  logic [15:0]       r_phase_count;
  logic              r_fault;
  logic [2:0]        r_fault_code;

  logic w_ns_g, w_ns_r, w_ew_g, w_ew_r;
  logic w_conflict, w_bad_head;
  logic w_ns_phase, w_ew_phase, w_all_red;
  logic w_dur_ok, w_dur_max;
  logic [2:0] w_viol;

  assign w_ns_g = NS_green & ~NS_red;
  assign w_ns_r = NS_red & ~NS_green;
  assign w_ew_g = EW_green & ~EW_red;
  assign w_ew_r = EW_red & ~EW_green;

  // Raw greens, not decoded ones: a head showing red+green still lights its green.
  assign w_conflict = NS_green & EW_green;
  assign w_bad_head = (NS_red == NS_green) | (EW_red == EW_green);

  assign w_ns_phase = w_ns_g & w_ew_r;
  assign w_ew_phase = w_ew_g & w_ns_r;
  assign w_all_red  = w_ns_r & w_ew_r;

  assign w_dur_ok  = (r_dur >= L_MIN);
  assign w_dur_max = (r_dur == L_MAX);

  // Violation for this edge, already resolved by priority (lower code wins).
  always_comb begin
    w_viol = C_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_conflict) w_viol = C_CONFLICT;
      end
      S_NS: begin
        if (w_conflict)                              w_viol = C_CONFLICT;
        else if (w_bad_head)                         w_viol = C_INVALID;
        else if ((w_all_red | w_ew_phase) && !w_dur_ok) w_viol = C_SHORT;
        else if (w_ns_phase && w_dur_max)            w_viol = C_LONG;
      end
      S_EW: begin
        if (w_conflict)                              w_viol = C_CONFLICT;
        else if (w_bad_head)                         w_viol = C_INVALID;
        else if ((w_all_red | w_ns_phase) && !w_dur_ok) w_viol = C_SHORT;
        else if (w_ew_phase && w_dur_max)            w_viol = C_LONG;
      end
      S_ALLRED: begin
        if (w_conflict)                  w_viol = C_CONFLICT;
        else if (w_bad_head)             w_viol = C_INVALID;
        else if (w_all_red && w_dur_max) w_viol = C_STUCK;
      end
      default: w_viol = C_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_dur         <= '0;
      r_phase_count <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= C_NONE;
    end else if (r_state == S_FAULT) begin
      r_state <= S_FAULT;
    end else if (w_viol != C_NONE) begin
      r_state      <= S_FAULT;
      r_fault      <= 1'b1;
      r_fault_code <= w_viol;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ns_phase) begin
            r_state       <= S_NS;
            r_dur         <= CNT_W'(1);
            r_phase_count <= r_phase_count + 16'd1;
          end else if (w_ew_phase) begin
            r_state       <= S_EW;
            r_dur         <= CNT_W'(1);
            r_phase_count <= r_phase_count + 16'd1;
          end else if (w_all_red) begin
            r_state <= S_ALLRED;
            r_dur   <= CNT_W'(1);
          end
        end
        S_NS: begin
          if (w_ns_phase) begin
            r_dur <= r_dur + 1'b1;
          end else if (w_all_red) begin
            r_state <= S_ALLRED;
            r_dur   <= CNT_W'(1);
          end else if (w_ew_phase) begin
            r_state       <= S_EW;
            r_dur         <= CNT_W'(1);
            r_phase_count <= r_phase_count + 16'd1;
          end
        end
        S_EW: begin
          if (w_ew_phase) begin
            r_dur <= r_dur + 1'b1;
          end else if (w_all_red) begin
            r_state <= S_ALLRED;
            r_dur   <= CNT_W'(1);
          end else if (w_ns_phase) begin
            r_state       <= S_NS;
            r_dur         <= CNT_W'(1);
            r_phase_count <= r_phase_count + 16'd1;
          end
        end
        S_ALLRED: begin
          if (w_all_red) begin
            r_dur <= r_dur + 1'b1;
          end else if (w_ns_phase) begin
            r_state       <= S_NS;
            r_dur         <= CNT_W'(1);
            r_phase_count <= r_phase_count + 16'd1;
          end else if (w_ew_phase) begin
            r_state       <= S_EW;
            r_dur         <= CNT_W'(1);
            r_phase_count <= r_phase_count + 16'd1;
          end
        end
        default: r_state <= S_FAULT;
      endcase
    end
  end

  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign mon_state   = r_state;
  assign phase_count = r_phase_count;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares one entry after every clock edge.
module tb_traffic_conflict_monitor;

  localparam int MIN_G = 3;
  localparam int MAX_G = 10;

  localparam logic [3:0] NSG = 4'b0110; // {NS_red, NS_green, EW_red, EW_green}
  localparam logic [3:0] EWG = 4'b1001;
  localparam logic [3:0] AR  = 4'b1010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        NS_red = 1'b1, NS_green = 1'b0, EW_red = 1'b1, EW_green = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  mon_state;
  logic [15:0] phase_count;

  traffic_conflict_monitor #(
    .MIN_GREEN(MIN_G),
    .MAX_GREEN(MAX_G),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .NS_red(NS_red),
    .NS_green(NS_green),
    .EW_red(EW_red),
    .EW_green(EW_green),
    .fault(fault),
    .fault_code(fault_code),
    .mon_state(mon_state),
    .phase_count(phase_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        f;
    logic [2:0]  code;
    logic [15:0] pc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void check(exp_t e);
    n_vec++;
    if ({mon_state, fault, fault_code, phase_count} !== {e.st, e.f, e.code, e.pc}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d fault=%0d code=%0d pc=%0d, expected state=%0d fault=%0d code=%0d pc=%0d",
               e.name, mon_state, fault, fault_code, phase_count, e.st, e.f, e.code, e.pc);
    end else begin
      $display("ok   %s: state=%0d fault=%0d code=%0d pc=%0d",
               e.name, mon_state, fault, fault_code, phase_count);
    end
  endfunction

  // Called at a falling edge: drive lamps, queue the result due after the next rising edge.
  task automatic vec(input logic [3:0] l, input logic [2:0] st, input logic f,
                     input logic [2:0] code, input logic [15:0] pc, input string name);
    exp_t e;
    {NS_red, NS_green, EW_red, EW_green} = l;
    e.st = st; e.f = f; e.code = code; e.pc = pc; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic vec_n(input int n, input logic [3:0] l, input logic [2:0] st, input logic f,
                       input logic [2:0] code, input logic [15:0] pc, input string name);
    for (int i = 0; i < n; i++) vec(l, st, f, code, pc, name);
  endtask

  // Reset must clear outputs immediately (checked off-edge), and hold them clear for 3 cycles.
  task automatic do_reset(input string name);
    exp_t e;
    e.st = 3'd0; e.f = 1'b0; e.code = 3'd0; e.pc = 16'd0;
    reset = 1'b1;
    #1;
    e.name = {name, "_async"};
    check(e);
    e.name = {name, "_held"};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e);
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check(exp_q.pop_front());
    end
  end

  initial begin : stimulus
    @(negedge clk);
    do_reset("por");

    // Two full legal cycles
    vec_n(5, NSG, 3'd1, 1'b0, 3'd0, 16'd1, "cyc_ns1");
    vec_n(2, AR,  3'd3, 1'b0, 3'd0, 16'd1, "cyc_ar1");
    vec_n(5, EWG, 3'd2, 1'b0, 3'd0, 16'd2, "cyc_ew1");
    vec_n(2, AR,  3'd3, 1'b0, 3'd0, 16'd2, "cyc_ar2");
    vec_n(5, NSG, 3'd1, 1'b0, 3'd0, 16'd3, "cyc_ns2");
    vec_n(2, AR,  3'd3, 1'b0, 3'd0, 16'd3, "cyc_ar3");
    vec_n(5, EWG, 3'd2, 1'b0, 3'd0, 16'd4, "cyc_ew2");
    vec_n(2, AR,  3'd3, 1'b0, 3'd0, 16'd4, "cyc_ar4");

    // Conflict from steady NS, then latched while inputs are legal again
    vec_n(3, NSG,     3'd1, 1'b0, 3'd0, 16'd5, "pre_conflict");
    vec(4'b0111,      3'd4, 1'b1, 3'd1, 16'd5, "conflict");
    vec_n(3, NSG,     3'd4, 1'b1, 3'd1, 16'd5, "latched");
    do_reset("rst_in_fault");

    // IDLE ignores bad heads but not conflicts
    vec(4'b0000, 3'd0, 1'b0, 3'd0, 16'd0, "idle_dark");
    vec(4'b1110, 3'd0, 1'b0, 3'd0, 16'd0, "idle_invalid");
    vec(4'b0101, 3'd4, 1'b1, 3'd1, 16'd0, "idle_conflict");
    do_reset("rst_idle");

    // Short green into all-red
    vec_n(2, NSG, 3'd1, 1'b0, 3'd0, 16'd1, "short_pre");
    vec(AR,       3'd4, 1'b1, 3'd3, 16'd1, "short_ns");
    do_reset("rst_short");

    // Direct handover at exactly MIN_GREEN, then short EW handover
    vec_n(3, NSG, 3'd1, 1'b0, 3'd0, 16'd1, "ho_ns");
    vec(EWG,      3'd2, 1'b0, 3'd0, 16'd2, "handover");
    vec(EWG,      3'd2, 1'b0, 3'd0, 16'd2, "ho_ew");
    vec(NSG,      3'd4, 1'b1, 3'd3, 16'd2, "short_ew");
    do_reset("rst_ho");

    // Longest legal green, then one more cycle
    vec_n(MAX_G, NSG, 3'd1, 1'b0, 3'd0, 16'd1, "long_ok");
    vec(NSG,          3'd4, 1'b1, 3'd4, 16'd1, "long_green");
    do_reset("rst_long");

    vec_n(MAX_G, AR, 3'd3, 1'b0, 3'd0, 16'd0, "allred_ok");
    vec(AR,          3'd4, 1'b1, 3'd5, 16'd0, "stuck_allred");
    do_reset("rst_stuck");

    // Priority: conflict beats invalid head
    vec_n(3, NSG,  3'd1, 1'b0, 3'd0, 16'd1, "prio_pre");
    vec(4'b1111,   3'd4, 1'b1, 3'd1, 16'd1, "prio_conflict");
    do_reset("rst_prio");

    vec_n(3, NSG,  3'd1, 1'b0, 3'd0, 16'd1, "dark_pre");
    vec(4'b0100,   3'd4, 1'b1, 3'd2, 16'd1, "ew_dark");
    do_reset("rst_dark");

    // Reset mid-EW with phase_count=3, then tracking resumes
    vec_n(3, EWG, 3'd2, 1'b0, 3'd0, 16'd1, "mid_ew1");
    vec_n(3, NSG, 3'd1, 1'b0, 3'd0, 16'd2, "mid_ns");
    vec_n(2, EWG, 3'd2, 1'b0, 3'd0, 16'd3, "mid_ew2");
    do_reset("rst_mid_ew");
    vec_n(3, NSG, 3'd1, 1'b0, 3'd0, 16'd1, "resume");

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
